// File: rtl/regarb_pkg.sv
// Shared types and widths for the register-file port arbiter.
package regarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam int REG_W  = 8;
  localparam int ADDR_W = 5;
  localparam int DBG_W  = 16;

  // Counter must be able to hold STARVE_LIMIT itself.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/regarb_starve_cnt.sv
// Saturating debugger wait counter; raises a registered stall request once
// the wait count reaches STARVE_LIMIT.
module regarb_starve_cnt
  import regarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic stall_clr,
  output logic stall
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    // NOTE: default first so every path assigns cnt_nxt and no latch is inferred.
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc && cnt != LIMIT)
      cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (rst) begin
      cnt   <= '0;
      stall <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (stall_clr)
        stall <= 1'b0;
      else if (inc && cnt_nxt == LIMIT)
        stall <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the AVR register-file ports between CPU (priority) and debugger.
// Define REGARB_WORD_EN to enable register-pair debug accesses.
module regfile_port_arbiter
  import regarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_use,
  input  logic [ADDR_W-1:0] cpu_addr1,
  input  logic [ADDR_W-1:0] cpu_addr2,
  input  logic [REG_W-1:0]  cpu_wdata1,
  input  logic [REG_W-1:0]  cpu_wdata2,
  input  logic              cpu_we1,
  input  logic              cpu_we2,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_word,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DBG_W-1:0]  dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DBG_W-1:0]  dbg_rdata,
  output logic [ADDR_W-1:0] rf_addr1,
  output logic [ADDR_W-1:0] rf_addr2,
  output logic [REG_W-1:0]  rf_wdata1,
  output logic [REG_W-1:0]  rf_wdata2,
  output logic              rf_we1,
  output logic              rf_we2,
  input  logic [REG_W-1:0]  rf_rdata1,
  input  logic [REG_W-1:0]  rf_rdata2
);

  state_t             state, state_nxt;
  logic               we_q, word_q, err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DBG_W-1:0]   wdata_q;
  logic               word_in;
  logic               bad, grant, leave_wait;

`ifdef REGARB_WORD_EN
  assign word_in = dbg_word;
`else
  logic unused_word;
  assign word_in     = 1'b0;
  assign unused_word = dbg_word;
`endif

  // Odd base address cannot form a register pair; rejected without access.
  assign bad        = word_q & addr_q[0];
  assign grant      = (state == WAIT) && !cpu_use && !bad && !rst;
  assign leave_wait = (state == WAIT) && (state_state_nxt_is_ack());

  function automatic logic state_state_nxt_is_ack();
    return state_nxt == ACK;
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dbg_req) state_nxt = WAIT;
      WAIT:    if (bad || !cpu_use) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && dbg_req) begin
        we_q    <= dbg_we;
        word_q  <= word_in;
        addr_q  <= dbg_addr;
        wdata_q <= dbg_wdata;
      end
      if (leave_wait)
        err_q <= bad;
      if (grant && !we_q)
        dbg_rdata <= {word_q ? rf_rdata2 : 8'h00, rf_rdata1};
    end
  end

  assign dbg_ack = (state == ACK);
  assign dbg_err = (state == ACK) && err_q;

  // CPU signals pass straight through except in the debugger's grant cycle.
  always_comb begin
    rf_addr1  = cpu_addr1;
    rf_addr2  = cpu_addr2;
    rf_wdata1 = cpu_wdata1;
    rf_wdata2 = cpu_wdata2;
    rf_we1    = cpu_we1;
    rf_we2    = cpu_we2;
    if (grant) begin
      rf_addr1  = addr_q;
      rf_wdata1 = wdata_q[7:0];
      rf_we1    = we_q;
      rf_we2    = 1'b0;
      if (word_q) begin
        rf_addr2  = addr_q + ADDR_W'(1);
        rf_wdata2 = wdata_q[15:8];
        rf_we2    = we_q;
      end
    end
  end

  regarb_starve_cnt #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      ((state == WAIT) && cpu_use && !bad),
    .clr      (state == ACK),
    .stall_clr(leave_wait),
    .stall    (cpu_stall)
  );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 32x8 register file.
// Expectations follow REGARB_WORD_EN when the bundle is built with it.
module tb_regfile_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_use;
  logic [4:0]  cpu_addr1, cpu_addr2;
  logic [7:0]  cpu_wdata1, cpu_wdata2;
  logic        cpu_we1, cpu_we2;
  logic        cpu_stall;
  logic        dbg_req, dbg_we, dbg_word;
  logic [4:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack, dbg_err;
  logic [15:0] dbg_rdata;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [7:0]  rf_wdata1, rf_wdata2;
  logic        rf_we1, rf_we2;
  logic [7:0]  rf_rdata1, rf_rdata2;

  logic [7:0]  rf [32];

  int checks   = 0;
  int failures = 0;

`ifdef REGARB_WORD_EN
  localparam logic [15:0] EXP_PAIR  = 16'h1234;
  localparam logic [4:0]  EXP_A2    = 5'd27;
  localparam logic        EXP_ERR   = 1'b1;
  localparam logic        EXP_WE7   = 1'b0;
`else
  localparam logic [15:0] EXP_PAIR  = 16'h0034;
  localparam logic [4:0]  EXP_A2    = 5'd0;
  localparam logic        EXP_ERR   = 1'b0;
  localparam logic        EXP_WE7   = 1'b1;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we1) rf[rf_addr1] <= rf_wdata1;
    if (rf_we2) rf[rf_addr2] <= rf_wdata2;
  end
  assign rf_rdata1 = rf[rf_addr1];
  assign rf_rdata2 = rf[rf_addr2];

  regfile_port_arbiter #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .cpu_use(cpu_use),
    .cpu_addr1(cpu_addr1), .cpu_addr2(cpu_addr2),
    .cpu_wdata1(cpu_wdata1), .cpu_wdata2(cpu_wdata2),
    .cpu_we1(cpu_we1), .cpu_we2(cpu_we2), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_word(dbg_word),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_wdata1(rf_wdata1), .rf_wdata2(rf_wdata2),
    .rf_we1(rf_we1), .rf_we2(rf_we2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg(input logic we, input logic word, input logic [4:0] addr,
                     input logic [15:0] wdata);
    dbg_req   = 1'b1;
    dbg_we    = we;
    dbg_word  = word;
    dbg_addr  = addr;
    dbg_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 8'h00;
    rst = 1'b1; cpu_use = 1'b0;
    cpu_addr1 = '0; cpu_addr2 = '0; cpu_wdata1 = '0; cpu_wdata2 = '0;
    cpu_we1 = 1'b0; cpu_we2 = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_word = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    tick(); tick();
    check("rst_ack", dbg_ack, 0);
    check("rst_err", dbg_err, 0);
    check("rst_rdata", dbg_rdata, 0);
    check("rst_stall", cpu_stall, 0);
    rst = 1'b0;

    // Byte write r5 = 0xA5, CPU idle
    dbg(1'b1, 1'b0, 5'd5, 16'h00A5);
    tick();
    check("bw_grant_we1", rf_we1, 1);
    check("bw_grant_addr1", rf_addr1, 5);
    check("bw_grant_wdata1", rf_wdata1, 8'hA5);
    check("bw_grant_we2", rf_we2, 0);
    check("bw_grant_noack", dbg_ack, 0);
    tick();
    check("bw_ack", dbg_ack, 1);
    check("bw_err", dbg_err, 0);
    check("bw_r5", rf[5], 8'hA5);
    check("bw_we1_done", rf_we1, 0);
    dbg_req = 1'b0;
    tick();
    check("bw_ack_pulse", dbg_ack, 0);

    // Preload r26/r27 through the CPU path
    cpu_use = 1'b1;
    cpu_addr1 = 5'd26; cpu_wdata1 = 8'h34; cpu_we1 = 1'b1;
    cpu_addr2 = 5'd27; cpu_wdata2 = 8'h12; cpu_we2 = 1'b1;
    #1;
    check("mirror_addr2", rf_addr2, 27);
    check("mirror_we2", rf_we2, 1);
    tick();
    cpu_use = 1'b0; cpu_we1 = 1'b0; cpu_we2 = 1'b0;
    cpu_addr1 = '0; cpu_addr2 = '0; cpu_wdata1 = '0; cpu_wdata2 = '0;
    check("pre_r26", rf[26], 8'h34);
    check("pre_r27", rf[27], 8'h12);

    // Word read of pair r27:r26
    dbg(1'b0, 1'b1, 5'd26, 16'h0000);
    tick();
    check("wr_grant_addr2", rf_addr2, EXP_A2);
    check("wr_grant_we1", rf_we1, 0);
    tick();
    check("wr_ack", dbg_ack, 1);
    check("wr_rdata", dbg_rdata, EXP_PAIR);
    dbg_req = 1'b0;
    tick();

    // Contention: CPU holds ports and writes r10 while debugger waits
    cpu_use = 1'b1; cpu_addr1 = 5'd10; cpu_wdata1 = 8'h5A; cpu_we1 = 1'b1;
    dbg(1'b1, 1'b0, 5'd3, 16'h0077);
    tick();
    check("ct_mirror_addr1", rf_addr1, 10);
    check("ct_mirror_wdata1", rf_wdata1, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      check("ct_stall_low", cpu_stall, 0);
      tick();
    end
    check("ct_stall_low4", cpu_stall, 0);
    tick();
    check("ct_stall_high", cpu_stall, 1);
    tick();
    check("ct_stall_hold", cpu_stall, 1);
    check("ct_no_forced_ack", dbg_ack, 0);
    check("ct_cpu_write", rf[10], 8'h5A);
    check("ct_no_dbg_write", rf[3], 8'h00);
    cpu_use = 1'b0; cpu_we1 = 1'b0; cpu_addr1 = '0; cpu_wdata1 = '0;
    #1;
    check("ct_grant_we1", rf_we1, 1);
    check("ct_grant_addr1", rf_addr1, 3);
    tick();
    check("ct_ack", dbg_ack, 1);
    check("ct_stall_clr", cpu_stall, 0);
    check("ct_r3", rf[3], 8'h77);
    dbg_req = 1'b0;
    tick();

    // Word write with odd address
    dbg(1'b1, 1'b1, 5'd7, 16'hBEEF);
    tick();
    check("odd_we1", rf_we1, EXP_WE7);
    check("odd_we2", rf_we2, 0);
    tick();
    check("odd_ack", dbg_ack, 1);
    check("odd_err", dbg_err, EXP_ERR);
    check("odd_rdata", dbg_rdata, EXP_PAIR);
    check("odd_r8", rf[8], 8'h00);
    dbg_req = 1'b0;
    tick();

    // Reset while waiting discards the request
    cpu_use = 1'b1;
    dbg(1'b1, 1'b0, 5'd9, 16'h0011);
    tick();
    rst = 1'b1; dbg_req = 1'b0; cpu_use = 1'b0;
    #1;
    check("rw_no_we", rf_we1, 0);
    tick();
    rst = 1'b0;
    check("rw_ack", dbg_ack, 0);
    check("rw_err", dbg_err, 0);
    check("rw_rdata", dbg_rdata, 0);
    check("rw_stall", cpu_stall, 0);
    check("rw_r9", rf[9], 8'h00);
    dbg(1'b0, 1'b0, 5'd5, 16'h0000);
    tick(); tick();
    check("rw_next_ack", dbg_ack, 1);
    check("rw_next_rdata", dbg_rdata, 16'h00A5);
    dbg_req = 1'b0;
    tick();

    // Back-to-back with dbg_req held high
    dbg(1'b1, 1'b0, 5'd12, 16'h00C3);
    tick(); tick();
    check("bb_ack1", dbg_ack, 1);
    check("bb_r12", rf[12], 8'hC3);
    dbg_addr = 5'd13; dbg_wdata = 16'h003C;
    tick();
    check("bb_gap1", dbg_ack, 0);
    tick();
    check("bb_gap2", dbg_ack, 0);
    check("bb_grant_addr1", rf_addr1, 13);
    tick();
    check("bb_ack2", dbg_ack, 1);
    check("bb_r13", rf[13], 8'h3C);
    check("bb_r12_kept", rf[12], 8'hC3);
    dbg_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
